// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus default sizing.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::DEF_WIDTH
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mthi;
    logic             mtlo;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, cancel,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one bit per i_step. Result is {high half, low half} of the accumulator.
module muldiv_core #(
    parameter int WIDTH = muldiv_pkg::DEF_WIDTH
) (
    input  logic               clk,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_part;
    logic [WIDTH:0]     w_diff;

    // Multiply: add the multiplicand into the high half when the low multiplier bit is set.
    assign w_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_part = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff = w_part - {1'b0, r_m};

    // NOTE: datapath registers have no reset; every op loads them before use.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
            r_m      <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            if (!r_is_div) begin
                r_acc <= {w_add, r_acc[WIDTH-1:1]};
            end else if (!w_diff[WIDTH]) begin
                r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                r_acc <= {w_part[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: control FSM, sign handling, HI/LO registers
// and MTHI/MTLO moves around the unsigned muldiv_core datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_e             r_state;
    op_e                r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    op_e                w_op;
    logic               w_signed;
    logic               w_launch;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_op     = op_e'(bus.op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_launch = (r_state == ST_IDLE) && bus.start && !bus.cancel;
    assign w_abs_a  = (w_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    assign w_abs_b  = (w_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .i_load   (w_launch),
        .i_step   (r_state == ST_CALC),
        .i_is_div (bus.op[1]),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_acc    (w_acc)
    );

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_fix_hi = w_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = w_acc[WIDTH-1:0];
        if (!r_op[1]) begin
            if (r_neg_q) {w_fix_hi, w_fix_lo} = -w_acc;
        end else if (r_div0) begin
            w_fix_hi = r_dividend;
            w_fix_lo = '1;
        end else begin
            if (r_neg_q) w_fix_lo = -w_acc[WIDTH-1:0];
            if (r_neg_r) w_fix_hi = -w_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_MULT;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_dividend <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state    <= ST_CALC;
                        r_cnt      <= '0;
                        r_op       <= w_op;
                        r_neg_q    <= w_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                        r_neg_r    <= (w_op == OP_DIV) && bus.operand_a[WIDTH-1];
                        r_div0     <= (bus.operand_b == '0);
                        r_dividend <= bus.operand_a;
                        r_busy     <= 1'b1;
                    end else if (!bus.start) begin
                        if (bus.mthi) r_hi <= bus.operand_a;
                        if (bus.mtlo) r_lo <= bus.operand_a;
                    end
                end
                ST_CALC: begin
                    if (bus.cancel) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.cancel) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: signed/unsigned mul/div,
// divide-by-zero, overflow case, moves, cancel and reset mid-op.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   busy_cyc;
    int   done_seen;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cyc++;
        if (bus.done) done_seen++;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cyc  = bus.busy ? 1 : 0;
        done_seen = 0;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int guard;
        guard = 0;
        while (!bus.done && guard < 60) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, "_busy_low"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        tick();
        check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        busy_cyc      = 0;
        done_seen     = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.mthi      = 1'b0;
        bus.mtlo      = 1'b0;
        bus.cancel    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);

        // Arithmetic vectors
        launch(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        finish_op("mult_m1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        finish_op("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        finish_op("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_min_m1", 32'h0000_0000, 32'h8000_0000);
        launch(OP_DIVU, 32'd100, 32'd7);
        finish_op("divu_100d7", 32'd2, 32'd14);
        launch(OP_DIVU, 32'd7, 32'd0);
        finish_op("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        finish_op("div_by0_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Moves in IDLE
        done_seen     = 0;
        bus.mthi      = 1'b1;
        bus.operand_a = 32'h0000_1234;
        tick();
        bus.mthi = 1'b0;
        check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
        check("mthi_lo_kept", {32'd0, bus.lo}, 64'hFFFF_FFFF);
        bus.mtlo      = 1'b1;
        bus.operand_a = 32'h0000_5678;
        tick();
        bus.mtlo = 1'b0;
        check("mtlo_lo", {32'd0, bus.lo}, 64'h5678);
        check("mtlo_hi_kept", {32'd0, bus.hi}, 64'h1234);
        bus.mthi      = 1'b1;
        bus.mtlo      = 1'b1;
        bus.operand_a = 32'h0000_ABCD;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mtboth_hi", {32'd0, bus.hi}, 64'hABCD);
        check("mtboth_lo", {32'd0, bus.lo}, 64'hABCD);
        check("moves_no_done", 64'(done_seen), 64'd0);

        // MTHI and a second start while busy are both ignored
        launch(OP_MULTU, 32'd3, 32'd5);
        tick();
        bus.mthi      = 1'b1;
        bus.operand_a = 32'h0000_DEAD;
        tick();
        bus.mthi      = 1'b0;
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        tick();
        bus.start = 1'b0;
        finish_op("busy_ignore", 32'd0, 32'd15);

        // start with mthi in the same cycle: the move is dropped
        bus.mthi      = 1'b1;
        bus.operand_a = 32'h0000_1111;
        tick();
        bus.mthi = 1'b0;
        check("pre_mthi", {32'd0, bus.hi}, 64'h1111);
        bus.mthi = 1'b1;
        launch(OP_MULTU, 32'd6, 32'd7);
        bus.mthi = 1'b0;
        check("start_mthi_dropped", {32'd0, bus.hi}, 64'h1111);
        finish_op("start_mthi", 32'd0, 32'd42);

        // cancel with start in IDLE suppresses the start
        bus.cancel = 1'b1;
        bus.start  = 1'b1;
        bus.op     = OP_MULT;
        tick();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("idle_cancel_busy", {63'd0, bus.busy}, 64'd0);

        // cancel mid-op
        launch(OP_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", {63'd0, bus.busy}, 64'd0);
        check("cancel_hi", {32'd0, bus.hi}, 64'd0);
        check("cancel_lo", {32'd0, bus.lo}, 64'd42);
        repeat (40) tick();
        check("cancel_no_done", 64'(done_seen), 64'd0);
        check("cancel_lo_later", {32'd0, bus.lo}, 64'd42);
        launch(OP_MULT, 32'd3, 32'd5);
        finish_op("after_cancel", 32'd0, 32'd15);

        // reset mid-op
        launch(OP_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) tick();
        check("midrst_no_done", 64'(done_seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit that consumes the two register-file read operands (rs, rt) in the execute stage.
- Computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- Exposes busy/done so the hazard logic can stall MFHI/MFLO and back-to-back mul/div ops.

Parameters:
WIDTH, 32, operand width and HI/LO width; product/remainder pair is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch op; sampled only in IDLE
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
mthi  input  1  write operand_a to HI
mtlo  input  1  write operand_a to LO
cancel  input  1  pipeline flush; abort in-flight op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  op in flight
done  output  1  one-cycle pulse when HI/LO updated by an op

Behaviour:
- Clocking and reset: single clock clk. reset is synchronous, active-high. On reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the op.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op, magnitudes of operands (signed ops: two's-complement abs), result signs; counter=0; go to CALC; busy=1 from E0.
  - start has priority over mthi/mtlo in the same cycle; the move is dropped.
- CALC: one iteration per cycle; counter increments; after WIDTH iterations (edge E32 for WIDTH=32) go to FIX.
  - Multiply: shift-add on unsigned magnitudes, 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX (edge E33): apply sign correction, write hi/lo, go to IDLE. At that edge busy->0 and done->1 for exactly one cycle.
  - Total: busy high for WIDTH+1 cycles.
- Sign rules:
  - MULT: product negated if signs differ.
  - DIV: quotient negated if signs differ; remainder takes dividend sign.
  - Unsigned ops: no correction.
- Divide by zero (any divide op): lo = all ones, hi = dividend as given (unmodified operand_a). Still takes the full WIDTH+1 cycles.
- DIV of -2^(WIDTH-1) by -1: lo = 0x80000000, hi = 0; no trap.
- mthi/mtlo:
  - Accepted only in IDLE with start=0; hi/lo update at the next edge; no done pulse.
  - Both asserted together: both written with operand_a.
  - Ignored while busy.
- start while busy: ignored, no queuing.
- cancel:
  - In CALC/FIX: state->IDLE next edge; hi/lo unchanged; busy=0; no done.
  - In IDLE: no effect. In IDLE with start=1: start is suppressed.
- hi/lo are registered outputs; never change except via FIX, mthi/mtlo, or reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encodings (ST_IDLE, ST_CALC, ST_FIX)
  - default WIDTH
- Natural sub-module: muldiv_core.
  - Contents: unsigned iterative shift-add/restoring datapath with step and load inputs.
  - Top level keeps the FSM, sign handling, HI/LO and moves.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> after 33 busy cycles done pulse; hi=0xFFFFFFFF lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF b=0x00000002 -> hi=0x00000001 lo=0xFFFFFFFE; busy exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=0x00000007; done after 33 cycles.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> hi/lo updated next edge, no done; MTHI during busy -> hi unchanged; start with mthi same cycle -> op runs, hi reflects op result.
- Start MULT 3*5, assert cancel at cycle 10 -> busy drops next edge, no done, hi/lo keep prior values; repeat with reset at cycle 10 -> hi=lo=0, idle.
